hex_rot_ctrl: RTL and testbench

Sequencing controller for the four-digit HEX display path on the board. It captures four 2-bit character codes, rotates them across hex_0..hex_3 on a programmable timebase, and supports pause and single-step. Each digit is decoded to active-low 7-segment patterns. It replaces the static switch-driven rotation muxes with a clocked scheduler that owns the digit-to-character mapping.

---
 rtl/hex_rot_pkg.sv | 23 ++
 rtl/hex_char_dec.sv | 20 ++
 rtl/hex_rot_ctrl.sv | 109 ++++++++++
 tb/tb_hex_rot_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_rot_pkg.sv
// Shared types and segment constants for the HEX rotation display path.
package hex_rot_pkg;

  typedef enum logic [1:0] {
    CHAR_D     = 2'b00,
    CHAR_E     = 2'b01,
    CHAR_ONE   = 2'b10,
    CHAR_BLANK = 2'b11
  } char_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_ONE   = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_char_dec.sv
// Combinational 2-bit character code to active-low 7-segment pattern.
module hex_char_dec
  import hex_rot_pkg::*;
(
  input  logic [1:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (char_t'(code))
      CHAR_D:     seg = SEG_D;
      CHAR_E:     seg = SEG_E;
      CHAR_ONE:   seg = SEG_ONE;
      CHAR_BLANK: seg = SEG_BLANK;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_rot_ctrl.sv
// Four-digit HEX rotation scheduler: FSM, prescaler, rotation counter, registered decode.
// Optional manual single-step in HOLD enabled by defining HEX_ROT_STEP_EN.
module hex_rot_ctrl
  import hex_rot_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] chars,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  output logic [6:0] hex_0,
  output logic [6:0] hex_1,
  output logic [6:0] hex_2,
  output logic [6:0] hex_3,
  output logic [1:0] rot_idx,
  output logic       tick
);

  localparam int unsigned PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  state_t        state;
  logic [7:0]    chars_q;
  logic [PW-1:0] presc;
  logic [1:0]    rot_adv;
  logic          step_edge;
  logic [6:0]    seg_w [4];
  logic [6:0]    hex_q [4];

  assign tick    = (state == RUN) & run & (presc == PRESC_LAST);
  assign rot_adv = dir ? rot_idx - 2'd1 : rot_idx + 2'd1;

`ifdef HEX_ROT_STEP_EN
  logic step_q;

  always_ff @(posedge clk) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end

  assign step_edge = step & ~step_q;
`else
  logic unused_step;
  assign unused_step = step;
  assign step_edge   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      chars_q <= '0;
      rot_idx <= '0;
      presc   <= '0;
    end else if (load) begin
      chars_q <= chars;
      rot_idx <= '0;
      presc   <= '0;
      state   <= run ? RUN : HOLD;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (!run) begin
            state <= HOLD;
            presc <= '0;
          end else if (tick) begin
            presc   <= '0;
            rot_idx <= rot_adv;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        HOLD: begin
          presc <= '0;
          if (step_edge) rot_idx <= rot_adv;
          if (run)       state   <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit k shows character (k + rot_idx) mod 4; 2-bit add wraps naturally.
  for (genvar k = 0; k < 4; k++) begin : g_dig
    logic [1:0] sel;
    assign sel = rot_idx + 2'(k);
    hex_char_dec u_dec (
      .code (chars_q[{sel, 1'b0} +: 2]),
      .seg  (seg_w[k])
    );
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (rst || state == IDLE) hex_q[i] <= SEG_BLANK;
      else                      hex_q[i] <= seg_w[i];
    end
  end

  assign hex_0 = hex_q[0];
  assign hex_1 = hex_q[1];
  assign hex_2 = hex_q[2];
  assign hex_3 = hex_q[3];

endmodule

// File: tb/tb_hex_rot_ctrl.sv
// Randomised self-checking bench for hex_rot_ctrl with a cycle-level behavioural model.
module tb_hex_rot_ctrl;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst, load, run, dir, step;
  logic [7:0] chars;
  logic [6:0] hex_0, hex_1, hex_2, hex_3;
  logic [1:0] rot_idx;
  logic       tick;

  int checks   = 0;
  int failures = 0;
  bit en = 1'b0;

  hex_rot_ctrl #(.TICK_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .load(load), .chars(chars), .run(run), .dir(dir),
    .step(step), .hex_0(hex_0), .hex_1(hex_1), .hex_2(hex_2), .hex_3(hex_3),
    .rot_idx(rot_idx), .tick(tick)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = blank/idle, 1 = auto-rotating, 2 = held
  int       m_mode = 0;
  int       m_chars [4] = '{0, 0, 0, 0};
  int       m_rot = 0;
  int       m_age = 0;
  bit       m_stepq = 1'b0;
  logic [6:0] m_hex [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};

  function automatic logic [6:0] seg_of(input int c);
    case (c)
      0:       return 7'h21;
      1:       return 7'h06;
      2:       return 7'h79;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic bit tick_exp();
    return (m_mode == 1) && run && (m_age == T - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [6:0] hn [4];
    bit te, edge_s;
    int d;
    te = tick_exp();
    d  = dir ? 3 : 1;
    for (int k = 0; k < 4; k++)
      hn[k] = (m_mode == 0) ? 7'h7F : seg_of(m_chars[(k + m_rot) % 4]);
    if (rst) begin
      m_mode = 0; m_rot = 0; m_age = 0; m_stepq = 1'b0;
      for (int k = 0; k < 4; k++) begin m_chars[k] = 0; m_hex[k] = 7'h7F; end
    end else begin
`ifdef HEX_ROT_STEP_EN
      edge_s = step && !m_stepq;
`else
      edge_s = 1'b0;
`endif
      m_stepq = step;
      if (load) begin
        for (int k = 0; k < 4; k++) m_chars[k] = (chars >> (2 * k)) & 3;
        m_rot = 0; m_age = 0;
        m_mode = run ? 1 : 2;
      end else if (m_mode == 1) begin
        if (!run) begin m_mode = 2; m_age = 0; end
        else if (te) begin m_rot = (m_rot + d) % 4; m_age = 0; end
        else m_age = m_age + 1;
      end else if (m_mode == 2) begin
        if (edge_s) m_rot = (m_rot + d) % 4;
        if (run) m_mode = 1;
      end
      for (int k = 0; k < 4; k++) m_hex[k] = hn[k];
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("rot_idx", 32'(rot_idx), 32'(m_rot));
      chk("tick", 32'(tick), 32'(tick_exp()));
      chk("hex_0", 32'(hex_0), 32'(m_hex[0]));
      chk("hex_1", 32'(hex_1), 32'(m_hex[1]));
      chk("hex_2", 32'(hex_2), 32'(m_hex[2]));
      chk("hex_3", 32'(hex_3), 32'(m_hex[3]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [7:0] c, input logic r);
    chars = c; run = r; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_model_rot(input int target, input string name);
    int n = 0;
    while (m_rot != target && n < 40) begin cyc(1); n++; end
    if (m_rot != target) chk({name, "_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; run = 1'b0; dir = 1'b0; step = 1'b0; chars = 8'h00;
    cyc(1);
    en = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("reset_hex0", 32'(hex_0), 32'h7F);
    chk("reset_hex3", 32'(hex_3), 32'h7F);
    chk("reset_rot", 32'(rot_idx), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chars = 8'hA5; run = 1'b1;
    cyc(3);
    chk("idle_blank", 32'(hex_1), 32'h7F);

    do_load(8'b11_10_01_00, 1'b0);
    chk("load_rot", 32'(rot_idx), 32'd0);
    cyc(1);
    chk("load_hex0", 32'(hex_0), 32'h21);
    chk("load_hex1", 32'(hex_1), 32'h06);
    chk("load_hex2", 32'(hex_2), 32'h79);
    chk("load_hex3", 32'(hex_3), 32'h7F);
    chk("load_notick", 32'(tick), 32'd0);

    // Auto-rotate forward, check mapping at offset 1
    run = 1'b1; dir = 1'b0;
    wait_model_rot(1, "fwd1");
    cyc(1);
    chk("rot1_hex0", 32'(hex_0), 32'h06);
    chk("rot1_hex3", 32'(hex_3), 32'h21);
    wait_model_rot(0, "fwd_wrap");
    dir = 1'b1;
    wait_model_rot(3, "rev3");
    chk("rev_rot", 32'(rot_idx), 32'd3);
    wait_model_rot(2, "rev2");
    dir = 1'b0;

    // Load landing on the tick cycle restarts the timebase
    do_load(8'b11_10_01_00, 1'b1);
    cyc(3);
    chk("tick_before_load", 32'(tick), 32'd1);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("load_over_tick_rot", 32'(rot_idx), 32'd0);
    cyc(2);
    chk("no_early_tick", 32'(tick), 32'd0);
    cyc(1);
    chk("restarted_tick", 32'(tick), 32'd1);

    // Step in HOLD: held high then re-pulsed
    do_load(8'b00_01_10_11, 1'b0);
    step = 1'b1; cyc(3);
    step = 1'b0; cyc(1);
    step = 1'b1; cyc(1);
    step = 1'b0; cyc(1);
`ifdef HEX_ROT_STEP_EN
    chk("step_advances", 32'(rot_idx), 32'd2);
`else
    chk("step_advances", 32'(rot_idx), 32'd0);
`endif

    // Reset mid-run at offset 2
    do_load(8'b10_01_00_11, 1'b1);
    wait_model_rot(2, "pre_rst");
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("rst_rot", 32'(rot_idx), 32'd0);
    cyc(1);
    chk("rst_hex0", 32'(hex_0), 32'h7F);
    chk("rst_hex2", 32'(hex_2), 32'h7F);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      load  = ($urandom_range(0, 19) == 0);
      chars = 8'($urandom);
      if ($urandom_range(0, 9) == 0) run = ~run;
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 2) == 0) step = ~step;
      cyc(1);
    end
    rst = 1'b0; load = 1'b0;
    cyc(2);
    en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
